// File: rtl/dbgtrace_pkg.sv
// rtl/dbgtrace_pkg.sv - shared types and register offsets for the debug trace capture
package dbgtrace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_POST_CNT = 12'h008;
  localparam logic [11:0] OFF_BP_EN    = 12'h00C;
  localparam logic [11:0] OFF_BP_BASE  = 12'h040;

  function automatic int words(input int pkg_w);
    return pkg_w / 32;
  endfunction

endpackage

// File: rtl/dbgtrace_ram.sv
// rtl/dbgtrace_ram.sv - DEPTH x PKG_W dual-port trace RAM, 1-cycle synchronous read
module dbgtrace_ram #(
  parameter int DEPTH = 128,
  parameter int PKG_W = 256,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PKG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PKG_W-1:0] rdata
);

  logic [PKG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dbgtrace.sv
// rtl/dbgtrace.sv - trace capture ring with PC breakpoints, post-trigger window and APB access
module dbgtrace
  import dbgtrace_pkg::*;
#(
  parameter int PKG_W     = 256,
  parameter int DEPTH     = 128,
  parameter int NBP       = 4,
  parameter int PC_LSB    = 160,
  parameter int FLUSH_BIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [12:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic             pkg_valid,
  input  logic [PKG_W-1:0] pkg,
  output logic             halt_req,
  output logic             trig_irq
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int WORDS = words(PKG_W);

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             wrapped;
  logic             trig;
  logic             halt_en;
  logic             irq_en;
  logic [7:0]       post_cnt;
  logic [7:0]       remaining;
  logic [NBP-1:0]   bp_en;
  logic [63:0]      bp [NBP];

  logic             rd_pend;
  logic             rd_ok;
  logic [2:0]       rd_word;
  logic [PKG_W-1:0] ram_rdata;

  logic [11:0]      off;
  logic             trace_acc;
  logic             wr_en;
  logic             ctrl_wr;
  logic             arm;
  logic             disarm;
  logic             hit_any;
  logic             hit;
  logic             capture;
  logic [6:0]       entry;
  logic [AW-1:0]    rd_slot;
  logic             entry_ok;
  logic [31:0]      status;
  logic [31:0]      reg_rd;
  logic [31:0]      word_sel;
  logic             unused_ok;

  assign off       = paddr[11:0];
  assign entry     = paddr[11:5];
  assign trace_acc = psel && penable && !paddr[12];
  // Trace reads stall exactly one cycle while the RAM output register fills.
  assign pready    = !(trace_acc && !rd_pend);
  assign pslverr   = 1'b0;
  assign wr_en     = psel && penable && pwrite && pready && paddr[12];
  assign ctrl_wr   = wr_en && (off == OFF_CTRL);
  assign arm       = ctrl_wr && pwdata[0];
  assign disarm    = ctrl_wr && pwdata[1];
  assign unused_ok = ^paddr[1:0];

  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < NBP; i++) begin
      if (bp_en[i] && (bp[i] == pkg[PC_LSB +: 64])) hit_any = 1'b1;
    end
  end

  assign hit     = pkg_valid && !pkg[FLUSH_BIT] && hit_any;
  assign capture = ((state == ST_ARMED) || (state == ST_POST)) && pkg_valid && !arm && !disarm;

  // Logical entry 0 is the oldest packet once the ring has wrapped.
  assign rd_slot  = (wrapped ? wr_ptr : '0) + entry[AW-1:0];
  assign entry_ok = (32'(entry) < 32'(count)) && (32'(paddr[4:2]) < WORDS);

  dbgtrace_ram #(.DEPTH(DEPTH), .PKG_W(PKG_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (pkg),
    .raddr (rd_slot),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_ok   <= 1'b0;
      rd_word <= 3'd0;
    end else begin
      rd_pend <= trace_acc && !rd_pend;
      rd_ok   <= entry_ok;
      rd_word <= paddr[4:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
      trig      <= 1'b0;
      halt_en   <= 1'b0;
      irq_en    <= 1'b0;
      post_cnt  <= 8'd0;
      remaining <= 8'd0;
      bp_en     <= '0;
      halt_req  <= 1'b0;
      for (int i = 0; i < NBP; i++) bp[i] <= 64'd0;
    end else begin
      if (ctrl_wr) begin
        halt_en <= pwdata[2];
        irq_en  <= pwdata[3];
      end
      if (wr_en && (off == OFF_POST_CNT))
        post_cnt <= (pwdata[7:0] > 8'(DEPTH-1)) ? 8'(DEPTH-1) : pwdata[7:0];
      if (wr_en && (off == OFF_BP_EN)) bp_en <= pwdata[NBP-1:0];
      for (int i = 0; i < NBP; i++) begin
        if (wr_en && (off == OFF_BP_BASE + 12'(8*i)))     bp[i][31:0]  <= pwdata;
        if (wr_en && (off == OFF_BP_BASE + 12'(8*i + 4))) bp[i][63:32] <= pwdata;
      end
      if (wr_en && (off == OFF_STATUS) && pwdata[3]) trig <= 1'b0;

      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == AW'(DEPTH-1)) wrapped <= 1'b1;
        if (count != CW'(DEPTH)) count <= count + 1'b1;
      end

      if (disarm) begin
        state <= ST_IDLE;
      end else if (arm) begin
        state   <= ST_ARMED;
        wr_ptr  <= '0;
        count   <= '0;
        wrapped <= 1'b0;
        trig    <= 1'b0;
      end else begin
        case (state)
          ST_ARMED: begin
            if (capture && hit) begin
              trig <= 1'b1;
              if (post_cnt == 8'd0) begin
                state <= ST_STOPPED;
              end else begin
                remaining <= post_cnt;
                state     <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (capture) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) state <= ST_STOPPED;
            end
          end
          default: ;
        endcase
      end

      halt_req <= halt_en && (state == ST_STOPPED);
    end
  end

  assign trig_irq = irq_en && trig;

  always_comb begin
    status        = 32'd0;
    status[1:0]   = state;
    status[2]     = wrapped;
    status[3]     = trig;
    status[14:8]  = 7'(wr_ptr);
    status[23:16] = 8'(count);
  end

  always_comb begin
    reg_rd = 32'd0;
    case (off)
      OFF_CTRL:     reg_rd = {28'd0, irq_en, halt_en, 2'b00};
      OFF_STATUS:   reg_rd = status;
      OFF_POST_CNT: reg_rd = {24'd0, post_cnt};
      OFF_BP_EN:    reg_rd = 32'(bp_en);
      default: begin
        for (int i = 0; i < NBP; i++) begin
          if (off == OFF_BP_BASE + 12'(8*i))     reg_rd = bp[i][31:0];
          if (off == OFF_BP_BASE + 12'(8*i + 4)) reg_rd = bp[i][63:32];
        end
      end
    endcase
  end

  always_comb begin
    word_sel = 32'd0;
    for (int w = 0; w < WORDS; w++) begin
      if (rd_word == 3'(w)) word_sel = ram_rdata[w*32 +: 32];
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (psel) begin
      if (paddr[12]) prdata = reg_rd;
      else if (rd_pend && rd_ok) prdata = word_sel;
    end
  end

endmodule
